// File: rtl/conv_window_feeder.sv
// conv_window_feeder: collects N kernel taps, then slides an N-deep sample
// window over each frame and hands out (window, taps) pairs for a
// downstream MAC. Data bits pass through untouched.
module conv_window_feeder #(
  parameter int IN_WIDTH     = 12,
  parameter int WEIGHT_WIDTH = 12,
  parameter int N            = 5,
  parameter int STRIDE       = 1,
  parameter int PAD          = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      w_valid,
  output logic                      w_ready,
  input  logic [WEIGHT_WIDTH-1:0]   w_data,
  output logic                      weights_loaded,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [IN_WIDTH-1:0]       s_data,
  input  logic                      s_last,
  output logic                      win_valid,
  input  logic                      win_ready,
  output logic [N*IN_WIDTH-1:0]     x_win,
  output logic [N*WEIGHT_WIDTH-1:0] h_win,
  output logic                      win_last,
  output logic                      err_short
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_READY  = 2'd2;
  localparam logic [1:0] ST_STREAM = 2'd3;

  localparam int XW     = N * IN_WIDTH;
  localparam int HW     = N * WEIGHT_WIDTH;
  localparam int IDX_W  = $clog2(N);
  localparam int FILL_W = $clog2(N + 1);
  localparam int STR_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [IDX_W-1:0]  LAST_TAP  = IDX_W'(N - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
  localparam logic [STR_W-1:0]  STR_LAST  = STR_W'(STRIDE - 1);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  w_idx_q, w_idx_d;
  logic [HW-1:0]     h_q, h_d;
  logic              loaded_q, loaded_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [STR_W-1:0]  stride_q, stride_d;
  logic              emitted_q, emitted_d;
  logic [XW-1:0]     x_q, x_d;
  logic              win_valid_q, win_valid_d;
  logic              win_last_q, win_last_d;
  logic              err_q, err_d;

  logic              w_fire, s_fire, in_frame, eligible, emit;
  logic [XW-1:0]     x_base, x_shift;
  logic [FILL_W-1:0] fill_base, fill_inc;
  logic [STR_W-1:0]  stride_base, stride_inc;
  logic              emitted_base;

  // Handshake readiness: taps may change only outside a frame; samples wait for a free output slot.
  always_comb begin
    w_ready = (state_q != ST_STREAM);
    s_ready = ((state_q == ST_READY) || (state_q == ST_STREAM)) && (!win_valid_q || win_ready);
    w_fire  = w_valid && w_ready;
    s_fire  = s_valid && s_ready;
  end

  // Window shift and emission decision for the sample on s_data; a new frame starts from a zeroed window.
  always_comb begin
    in_frame     = (state_q == ST_STREAM);
    x_base       = in_frame ? x_q : {XW{1'b0}};
    fill_base    = in_frame ? fill_q : {FILL_W{1'b0}};
    stride_base  = in_frame ? stride_q : {STR_W{1'b0}};
    emitted_base = in_frame ? emitted_q : 1'b0;
    x_shift      = {s_data, x_base[XW-1:IN_WIDTH]};
    fill_inc     = (fill_base == FILL_FULL) ? FILL_FULL : fill_base + FILL_W'(1);
    eligible     = (PAD != 0) || (fill_inc == FILL_FULL);
    emit         = eligible && ((stride_base == {STR_W{1'b0}}) || s_last);
    if (eligible) begin
      stride_inc = (stride_base == STR_LAST) ? {STR_W{1'b0}} : stride_base + STR_W'(1);
    end else begin
      stride_inc = stride_base;
    end
  end

  // Next-state logic: tap loading by state, then sample acceptance, then output slot bookkeeping.
  always_comb begin
    state_d     = state_q;
    w_idx_d     = w_idx_q;
    h_d         = h_q;
    loaded_d    = loaded_q;
    fill_d      = fill_q;
    stride_d    = stride_q;
    emitted_d   = emitted_q;
    x_d         = x_q;
    win_last_d  = win_last_q;
    err_d       = 1'b0;
    if (win_valid_q && win_ready) begin
      win_valid_d = 1'b0;
    end else begin
      win_valid_d = win_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (w_fire) begin
          h_d[WEIGHT_WIDTH-1:0] = w_data;
          w_idx_d  = IDX_W'(1);
          loaded_d = 1'b0;
          state_d  = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (w_fire) begin
          h_d[w_idx_q*WEIGHT_WIDTH +: WEIGHT_WIDTH] = w_data;
          if (w_idx_q == LAST_TAP) begin
            loaded_d = 1'b1;
            w_idx_d  = {IDX_W{1'b0}};
            state_d  = ST_READY;
          end else begin
            w_idx_d = w_idx_q + IDX_W'(1);
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_READY: begin
        // A sample arriving together with a weight starts the frame; that weight word is dropped.
        if (w_fire && !s_fire) begin
          h_d[WEIGHT_WIDTH-1:0] = w_data;
          w_idx_d  = IDX_W'(1);
          loaded_d = 1'b0;
          state_d  = ST_LOAD;
        end else begin
          state_d = ST_READY;
        end
      end
      ST_STREAM: begin
        state_d = ST_STREAM;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (s_fire) begin
      x_d       = x_shift;
      fill_d    = fill_inc;
      stride_d  = stride_inc;
      emitted_d = emitted_base || emit;
      state_d   = ST_STREAM;
      if (emit) begin
        win_valid_d = 1'b1;
        win_last_d  = s_last;
      end else begin
        win_last_d = win_last_q;
      end
      if (s_last) begin
        state_d   = ST_READY;
        fill_d    = {FILL_W{1'b0}};
        stride_d  = {STR_W{1'b0}};
        emitted_d = 1'b0;
        err_d     = !(emitted_base || emit);
      end else begin
        err_d = 1'b0;
      end
    end else begin
      x_d = x_q;
    end
  end

  // State registers; reset drops any partial taps, window and pending output at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      w_idx_q     <= {IDX_W{1'b0}};
      h_q         <= {HW{1'b0}};
      loaded_q    <= 1'b0;
      fill_q      <= {FILL_W{1'b0}};
      stride_q    <= {STR_W{1'b0}};
      emitted_q   <= 1'b0;
      x_q         <= {XW{1'b0}};
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_idx_q     <= w_idx_d;
      h_q         <= h_d;
      loaded_q    <= loaded_d;
      fill_q      <= fill_d;
      stride_q    <= stride_d;
      emitted_q   <= emitted_d;
      x_q         <= x_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      err_q       <= err_d;
    end
  end

  assign weights_loaded = loaded_q;
  assign win_valid      = win_valid_q;
  assign x_win          = x_q;
  assign h_win          = h_q;
  assign win_last       = win_last_q;
  assign err_short      = err_q;

endmodule

// File: doc/conv_window_feeder.md
CONV_WINDOW_FEEDER -- requirements
Module: conv_window_feeder

Interface
REQ-001 Parameter IN_WIDTH, default 12: sample width, two's complement.
REQ-002 Parameter WEIGHT_WIDTH, default 12: weight width, two's complement.
REQ-003 Parameter N, default 5: kernel length and window depth, N>=2.
REQ-004 Parameter STRIDE, default 1: output decimation, STRIDE>=1.
REQ-005 Parameter PAD, default 0: 1 means zero-prefilled causal window, 0 means valid-only windows.
REQ-006 Clock and reset SHALL be one clock and an asynchronous, active-high reset.
REQ-007 clk  input  1  clock; all state changes on rising edge.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 w_valid  input  1  weight word present.
REQ-010 w_ready  output  1  weight word accepted when w_valid&&w_ready.
REQ-011 w_data  input  WEIGHT_WIDTH  weight word, first word is tap 0.
REQ-012 weights_loaded  output  1  all N taps held.
REQ-013 s_valid  input  1  sample present.
REQ-014 s_ready  output  1  sample accepted when s_valid&&s_ready.
REQ-015 s_data  input  IN_WIDTH  sample.
REQ-016 s_last  input  1  sample is last of frame.
REQ-017 win_valid  output  1  window present.
REQ-018 win_ready  input  1  window consumed when win_valid&&win_ready.
REQ-019 x_win  output  N*IN_WIDTH  sample window, slice N-1 newest, slice 0 oldest.
REQ-020 h_win  output  N*WEIGHT_WIDTH  taps, slice k = k-th weight loaded.
REQ-021 win_last  output  1  window is last of frame, qualified by win_valid.
REQ-022 err_short  output  1  one-cycle pulse: frame ended with no window emitted.

Function
REQ-023 FSM states: IDLE (no taps), LOAD (taps 1..N-1 received), READY (taps held, between frames), STREAM (in frame).
REQ-024 w_ready=1 in IDLE, LOAD, READY; 0 in STREAM (w_valid ignored, no tap change).
REQ-025 Accepted weight in IDLE/READY: writes tap 0, w_idx=1, weights_loaded=0, go LOAD; in LOAD: writes tap w_idx; tap N-1 sets weights_loaded=1, go READY.
REQ-026 s_ready = (state READY or STREAM) && (!win_valid || win_ready); combinational.
REQ-027 Accepted sample in READY: go STREAM; fill_cnt and stride_cnt start from 0; window prefilled with zeros before the shift.
REQ-028 Each accepted sample shifts x_win: slice i takes slice i+1, slice N-1 takes s_data; fill_cnt saturates at N.
REQ-029 Sample is eligible if PAD=1 or post-increment fill_cnt==N.
REQ-030 stride_cnt advances modulo STRIDE on eligible samples only; window emitted if eligible and (stride_cnt==0 or s_last).
REQ-031 Emission: win_valid=1 next cycle with updated x_win; win_last=s_last of that sample; latency one cycle from acceptance.
REQ-032 win_valid, x_win, win_last held stable until win_ready; simultaneous consume and new emission in the same cycle allowed (no bubble).
REQ-033 Accepted s_last: go READY, counters cleared; if no window emitted in the frame, err_short pulses the following cycle.
REQ-034 h_win always drives current taps; unchanged during STREAM.
REQ-035 No arithmetic on data; bits passed unmodified.

Reset
REQ-036 rst: state IDLE, w_idx=0, fill_cnt=0, stride_cnt=0, x_win=0, h_win=0, weights_loaded=0, win_valid=0, win_last=0, err_short=0, w_ready=1, s_ready=0.
REQ-037 rst mid-LOAD or mid-STREAM discards partial taps, window and pending output immediately.

Verification
REQ-038 Load taps 3 of 5, assert rst -> weights_loaded=0, h_win=0, w_ready=1, win_valid=0.
REQ-039 Taps 1..5, PAD=0, STRIDE=1, frame 1..8 -> 4 windows; first x_win slices 0..4=1,2,3,4,5; last=4..8 with win_last=1.
REQ-040 PAD=1, frame 7,8 -> first window slices=0,0,0,0,7; second=0,0,0,7,8 with win_last=1.
REQ-041 win_ready held 0 for 3 cycles with win_valid=1 -> x_win stable, s_ready=0; accepting resumes the cycle win_ready=1.
REQ-042 STRIDE=2, PAD=0, frame 1..8 -> windows ending at 5, 7, and 8 (forced by s_last, win_last=1).
REQ-043 PAD=0, frame of 3 samples -> no window, err_short high exactly 1 cycle, state READY; w_valid during STREAM -> h_win unchanged.
